// File: rtl/mux2_stream_arbiter.sv
// Two-input round-robin stream arbiter with optional packet lock and a
// registered output stage. The grant steers a 2:1 mux carrying
// {valid, last, data}, and the winning beat is captured into the output register.

// Plain 2:1 selector; sel=0 passes a, sel=1 passes b.
module mux_2to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

module mux2_stream_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter bit          LOCK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,

    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } state_e;

    state_e state_q;
    // Preferred source when both inputs request in StIdle.
    logic   prio_q;

    logic   grant;
    logic   sel;
    logic   can_load;
    logic   accept;

    logic [WIDTH+1:0] mux_a;
    logic [WIDTH+1:0] mux_b;
    logic [WIDTH+1:0] mux_y;

    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    // Grant decision: a lock pins the selection, otherwise round-robin on contention.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        case (state_q)
            StIdle: begin
                if (in0_valid && in1_valid) begin
                    grant = 1'b1;
                    sel   = prio_q;
                end else if (in0_valid) begin
                    grant = 1'b1;
                    sel   = 1'b0;
                end else if (in1_valid) begin
                    grant = 1'b1;
                    sel   = 1'b1;
                end
            end
            StLock0: begin
                grant = 1'b1;
                sel   = 1'b0;
            end
            StLock1: begin
                grant = 1'b1;
                sel   = 1'b1;
            end
            default: begin
                grant = 1'b0;
                sel   = 1'b0;
            end
        endcase
    end

    assign mux_a = {in0_valid, in0_last, in0_data};
    assign mux_b = {in1_valid, in1_last, in1_data};

    mux_2to1 #(
        .WIDTH(WIDTH + 2)
    ) u_mux (
        .sel(sel),
        .a  (mux_a),
        .b  (mux_b),
        .y  (mux_y)
    );

    assign sel_valid = mux_y[WIDTH+1];
    assign sel_last  = mux_y[WIDTH];
    assign sel_data  = mux_y[WIDTH-1:0];

    // The output register can take a beat when empty or being drained this cycle.
    assign can_load  = ~out_valid | out_ready;
    assign in0_ready = can_load & grant & ~sel;
    assign in1_ready = can_load & grant & sel;
    assign accept    = grant & can_load & sel_valid;

    // Output register, lock state and round-robin pointer, all updated on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prio_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else begin
            if (can_load) begin
                out_valid <= accept;
            end
            if (accept) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_src  <= sel;
                // End of packet (or no locking): release and hand priority to the other side.
                if (sel_last || !LOCK_EN) begin
                    state_q <= StIdle;
                    prio_q  <= ~sel;
                end else begin
                    state_q <= sel ? StLock1 : StLock0;
                end
            end
        end
    end

endmodule
